// File: rtl/conv_pkg.sv
// Shared types for the convolution sequencer: FSM state encoding and the
// number of valid (fully overlapped) outputs for a given memory geometry.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        LOAD_X,
        MAC,
        DRAIN,
        OUT,
        DONE
    } seq_state_e;

    function automatic int y_count(input int x_size, input int f_size);
        return x_size - f_size + 1;
    endfunction

endpackage

// File: rtl/conv_sequencer_rise_edge_det.sv
// Rising-edge detector for a level input; the pulse is combinational from the
// current level and the registered previous level.
module rise_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic din_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/conv_sequencer.sv
// Control sequencer for the 1-D convolution datapath: loads f and x memories,
// then runs one multiply-accumulate pass per output and hands each y downstream.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int F_MEM_SIZE       = 4,
    parameter int X_MEM_SIZE       = 8,
    parameter int F_MEM_ADDR_WIDTH = 2,
    parameter int X_MEM_ADDR_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        conv_start,
    input  logic                        s_valid_f,
    output logic                        s_ready_f,
    input  logic                        s_valid_x,
    output logic                        s_ready_x,
    output logic                        f_wr_en,
    output logic                        x_wr_en,
    output logic [F_MEM_ADDR_WIDTH-1:0] f_addr,
    output logic [X_MEM_ADDR_WIDTH-1:0] x_addr,
    output logic                        acc_clr,
    output logic                        acc_en,
    output logic                        m_valid_y,
    input  logic                        m_ready_y,
    output logic                        conv_done
);

    localparam int Y_COUNT = y_count(X_MEM_SIZE, F_MEM_SIZE);

    localparam logic [F_MEM_ADDR_WIDTH-1:0] F_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] X_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] Y_LAST = X_MEM_ADDR_WIDTH'(Y_COUNT - 1);
    localparam logic [F_MEM_ADDR_WIDTH-1:0] F_ONE  = F_MEM_ADDR_WIDTH'(1);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] X_ONE  = X_MEM_ADDR_WIDTH'(1);

    seq_state_e                  state;
    logic [F_MEM_ADDR_WIDTH-1:0] f_cnt;
    logic [X_MEM_ADDR_WIDTH-1:0] x_cnt;
    logic [X_MEM_ADDR_WIDTH-1:0] n;
    logic [F_MEM_ADDR_WIDTH-1:0] k;
    logic                        start_pulse;
    logic [X_MEM_ADDR_WIDTH:0]   n_ext;
    logic [X_MEM_ADDR_WIDTH:0]   k_ext;

    rise_edge_det u_start_edge (
        .clk   (clk),
        .reset (reset),
        .din   (conv_start),
        .pulse (start_pulse)
    );

    assign f_wr_en = s_valid_f & s_ready_f;
    assign x_wr_en = s_valid_x & s_ready_x;

    // Sample index n+k gets one extra bit of headroom before truncation.
    assign n_ext  = {1'b0, n};
    assign k_ext  = {{(X_MEM_ADDR_WIDTH + 1 - F_MEM_ADDR_WIDTH){1'b0}}, k};
    assign f_addr = (state == MAC) ? k : f_cnt;
    assign x_addr = (state == MAC) ? X_MEM_ADDR_WIDTH'(n_ext + k_ext) : x_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            f_cnt     <= '0;
            x_cnt     <= '0;
            n         <= '0;
            k         <= '0;
            s_ready_f <= 1'b0;
            s_ready_x <= 1'b0;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            m_valid_y <= 1'b0;
            conv_done <= 1'b0;
        end else begin
            acc_en    <= 1'b0;
            acc_clr   <= 1'b0;
            conv_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        f_cnt     <= '0;
                        x_cnt     <= '0;
                        s_ready_f <= 1'b1;
                        state     <= LOAD_F;
                    end
                end
                LOAD_F: begin
                    if (f_wr_en) begin
                        if (f_cnt == F_LAST) begin
                            f_cnt     <= '0;
                            s_ready_f <= 1'b0;
                            s_ready_x <= 1'b1;
                            state     <= LOAD_X;
                        end else begin
                            f_cnt <= f_cnt + F_ONE;
                        end
                    end
                end
                LOAD_X: begin
                    if (x_wr_en) begin
                        if (x_cnt == X_LAST) begin
                            x_cnt     <= '0;
                            s_ready_x <= 1'b0;
                            n         <= '0;
                            k         <= '0;
                            state     <= MAC;
                        end else begin
                            x_cnt <= x_cnt + X_ONE;
                        end
                    end
                end
                // Memory read latency is one cycle, so the accumulate strobe
                // for tap k lands the cycle after its read is issued.
                MAC: begin
                    acc_en  <= 1'b1;
                    acc_clr <= (k == '0);
                    if (k == F_LAST) begin
                        k     <= '0;
                        state <= DRAIN;
                    end else begin
                        k <= k + F_ONE;
                    end
                end
                DRAIN: begin
                    m_valid_y <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (m_valid_y && m_ready_y) begin
                        m_valid_y <= 1'b0;
                        if (n == Y_LAST) begin
                            conv_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            n     <= n + X_ONE;
                            state <= MAC;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
